// File: rtl/cache_mem_responder.sv
// Line-oriented memory responder: accepts one read or write request at a time
// and acknowledges it a fixed LATENCY cycles later with a one-cycle pulse.
module cache_mem_responder #(
  parameter int BYTE_NUM  = 8,
  parameter int ADDR_SIZE = 12,
  parameter int LATENCY   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_rd_en,
  input  logic                    mem_wr_en,
  input  logic [ADDR_SIZE-1:0]    mem_addr,
  input  logic [8*BYTE_NUM-1:0]   mem_wr_data,
  input  logic [BYTE_NUM-1:0]     mem_sel,
  output logic                    mem_ack,
  output logic [8*BYTE_NUM-1:0]   mem_rd_data,
  output logic                    busy,
  output logic                    proto_err
);

  localparam int OFF_W  = $clog2(BYTE_NUM);
  localparam int LINE_W = ADDR_SIZE - OFF_W;
  localparam int DEPTH  = 2 ** LINE_W;
  localparam int CNT_W  = $clog2(LATENCY) + 1;
  localparam int DATA_W = 8 * BYTE_NUM;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [LINE_W-1:0]   line_r;
  logic                is_read_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                accept_s;
  logic                write_s;
  logic [LINE_W-1:0]   line_s;

  assign accept_s = (state_r == S_IDLE) && (mem_rd_en || mem_wr_en);
  // A simultaneous rd/wr request is a write, so the write enable alone decides.
  assign write_s  = accept_s && mem_wr_en;
  assign line_s   = mem_addr[ADDR_SIZE-1:OFF_W];

  // Request sequencing, latency counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      line_r      <= {LINE_W{1'b0}};
      is_read_r   <= 1'b0;
      mem_ack     <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
      mem_rd_data <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          mem_ack <= 1'b0;
          if (accept_s) begin
            line_r    <= line_s;
            is_read_r <= !mem_wr_en;
            busy      <= 1'b1;
            if (mem_rd_en && mem_wr_en) begin
              proto_err <= 1'b1;
            end else begin
              proto_err <= proto_err;
            end
            if (LATENCY == 1) begin
              state_r <= S_ACK;
              mem_ack <= 1'b1;
              if (!mem_wr_en) begin
                mem_rd_data <= mem_r[line_s];
              end else begin
                mem_rd_data <= mem_rd_data;
              end
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= CNT_W'(LATENCY - 1);
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_WAIT: begin
          // The counter was loaded with LATENCY-1, so Wait spans LATENCY-1 cycles.
          if (cnt_r <= CNT_W'(1)) begin
            state_r <= S_ACK;
            cnt_r   <= {CNT_W{1'b0}};
            mem_ack <= 1'b1;
            if (is_read_r) begin
              mem_rd_data <= mem_r[line_r];
            end else begin
              mem_rd_data <= mem_rd_data;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        S_ACK: begin
          state_r <= S_IDLE;
          mem_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          mem_ack <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: byte-masked write committed at the acceptance edge, never reset.
  always_ff @(posedge clock) begin
    if (write_s) begin
      for (int b = 0; b < BYTE_NUM; b++) begin
        if (mem_sel[b]) begin
          mem_r[line_s][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed vector table, multi-cycle
// corner sequences and randomized traffic against a line-array reference model.
module tb_cache_mem_responder;

  localparam int LAT = 3;

  logic        clock;
  logic        reset;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [11:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_sel;
  logic        mem_ack;
  logic [63:0] mem_rd_data;
  logic        busy;
  logic        proto_err;

  int tests  = 0;
  int errors = 0;

  // Reference model: plain line array plus the last read value and sticky error.
  logic [63:0] m_mem [512];
  logic [63:0] m_rd;
  logic        m_perr;

  cache_mem_responder #(.BYTE_NUM(8), .ADDR_SIZE(12), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_sel     (mem_sel),
    .mem_ack     (mem_ack),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  sel;
    logic [63:0] exp_rd;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_write(input logic [11:0] addr, input logic [63:0] data, input logic [7:0] sel);
    for (int b = 0; b < 8; b++) begin
      if (sel[b]) m_mem[addr[11:3]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // One transaction: request driven in cycle 0, dropped after acceptance.
  task automatic txn(input logic rd, input logic wr, input logic [11:0] addr,
                     input logic [63:0] data, input logic [7:0] sel, input bit scramble);
    @(negedge clock);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_ack", {63'd0, mem_ack}, 64'd0);
    chk("rd_hold", mem_rd_data, m_rd);
    mem_rd_en   = rd;
    mem_wr_en   = wr;
    mem_addr    = addr;
    mem_wr_data = data;
    mem_sel     = sel;
    if (wr) begin
      model_write(addr, data, sel);
      if (rd) m_perr = 1'b1;
    end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      if (k == 1) begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        if (scramble) begin
          mem_addr    = 12'($urandom);
          mem_wr_data = {$urandom, $urandom};
          mem_sel     = 8'($urandom);
        end
      end
      chk("ack_timing", {63'd0, mem_ack}, {63'd0, (k == LAT)});
      chk("busy_inflight", {63'd0, busy}, 64'd1);
      if (k == LAT) begin
        if (rd && !wr) m_rd = m_mem[addr[11:3]];
        chk("rd_data_at_ack", mem_rd_data, m_rd);
        chk("proto_err", {63'd0, proto_err}, {63'd0, m_perr});
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 12'd0;
    mem_wr_data = 64'd0;
    mem_sel     = 8'd0;
    m_rd        = 64'd0;
    m_perr      = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 12'h010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 12'h017, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h1122334455667788, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 12'h010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 12'h020, 64'h5, 8'hFF, 64'h11223344AAAAAAAA, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 12'h020, 64'h0, 8'h00, 64'h5, 1'b1};

    #1;
    chk("reset_ack", {63'd0, mem_ack}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_perr", {63'd0, proto_err}, 64'd0);
    chk("reset_rd_data", mem_rd_data, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].sel, 1'b0);
      chk("vec_rd_data", mem_rd_data, vecs[i].exp_rd);
      chk("vec_perr", {63'd0, proto_err}, {63'd0, vecs[i].exp_perr});
    end

    // Request held through ack: re-accepted in the cycle after ack, single extra ack.
    @(negedge clock);
    mem_rd_en = 1'b1;
    mem_addr  = 12'h010;
    for (int k = 1; k <= 2*LAT + 1; k++) begin
      @(negedge clock);
      if (k == LAT + 2) mem_rd_en = 1'b0;
      if (k == LAT) m_rd = m_mem[2];
      chk("b2b_ack", {63'd0, mem_ack}, {63'd0, (k == LAT) || (k == 2*LAT + 1)});
      chk("b2b_busy", {63'd0, busy}, {63'd0, (k != LAT + 1)});
    end
    chk("b2b_rd_data", mem_rd_data, 64'h11223344AAAAAAAA);
    @(negedge clock);
    chk("b2b_no_extra_ack", {63'd0, mem_ack}, 64'd0);
    chk("b2b_idle", {63'd0, busy}, 64'd0);

    // Reset during Wait: aborts with no ack, accepted write stays committed.
    mem_wr_en   = 1'b1;
    mem_addr    = 12'h028;
    mem_wr_data = 64'hDEADBEEFCAFEF00D;
    mem_sel     = 8'hFF;
    model_write(12'h028, 64'hDEADBEEFCAFEF00D, 8'hFF);
    @(negedge clock);
    mem_wr_en = 1'b0;
    chk("rst_pre_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ack", {63'd0, mem_ack}, 64'd0);
    chk("rst_perr", {63'd0, proto_err}, 64'd0);
    chk("rst_rd_data", mem_rd_data, 64'd0);
    m_perr = 1'b0;
    m_rd   = 64'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rst_no_ack", {63'd0, mem_ack}, 64'd0);
    end
    reset = 1'b1;
    txn(1'b1, 1'b0, 12'h02C, 64'h0, 8'h00, 1'b0);
    chk("rst_committed", mem_rd_data, 64'hDEADBEEFCAFEF00D);

    // Randomized traffic over lines 0..15, all initialised first.
    for (int l = 0; l < 16; l++) begin
      txn(1'b0, 1'b1, 12'(l * 8), {$urandom, $urandom}, 8'hFF, 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [11:0] a;
      op = $urandom_range(0, 9);
      a  = 12'($urandom_range(0, 127));
      if (op == 0)
        txn(1'b1, 1'b1, a, {$urandom, $urandom}, 8'($urandom), 1'($urandom));
      else if (op <= 4)
        txn(1'b0, 1'b1, a, {$urandom, $urandom}, 8'($urandom), 1'($urandom));
      else
        txn(1'b1, 1'b0, a, {$urandom, $urandom}, 8'($urandom), 1'($urandom));
    end

    @(negedge clock);
    chk("final_idle", {63'd0, busy}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter BYTE_NUM, default 8: line width in bytes (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_SIZE, default 12: byte-address width; line count DEPTH = 2**(ADDR_SIZE-log2(BYTE_NUM)).
REQ-003 SHALL have parameter LATENCY, default 3: cycles from request acceptance to ack (>=1).
REQ-004 SHALL have port clock  in  1  system clock; one clock domain, all state on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_rd_en  in  1  line read request, level, held by initiator until ack.
REQ-007 SHALL have port mem_wr_en  in  1  line write request, level, held by initiator until ack.
REQ-008 SHALL have port mem_addr  in  ADDR_SIZE  byte address; low log2(BYTE_NUM) bits ignored.
REQ-009 SHALL have port mem_wr_data  in  8*BYTE_NUM  write line data.
REQ-010 SHALL have port mem_sel  in  BYTE_NUM  per-byte write enable.
REQ-011 SHALL have port mem_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_rd_data  out  8*BYTE_NUM  read line data.
REQ-013 SHALL have port busy  out  1  high while a request is in flight (not Idle).
REQ-014 SHALL have port proto_err  out  1  sticky flag, simultaneous rd/wr request seen.

Function
REQ-015 SHALL implement FSM states Idle, Wait, Ack; Ack lasts exactly one cycle.
REQ-016 Idle SHALL accept a request when mem_rd_en or mem_wr_en is high at a rising edge, capturing mem_addr, mem_wr_data, mem_sel and request type in that edge.
REQ-017 For request high in cycle 0 (Idle), mem_ack SHALL be high in cycle LATENCY only; LATENCY=1 goes Idle->Ack directly, else Idle->Wait for LATENCY-1 cycles via down-counter of width clog2(LATENCY)+1.
REQ-018 Ack SHALL always return to Idle; requests are not sampled in Ack, so a new request is accepted no earlier than the cycle after ack.
REQ-019 Writes SHALL update only bytes whose captured mem_sel bit is 1, at the acceptance edge; unselected bytes retain value.
REQ-020 Reads SHALL load mem_rd_data from the captured line index on the edge entering Ack; mem_rd_data SHALL hold until the next read load.
REQ-021 Writes SHALL not modify mem_rd_data.
REQ-022 mem_rd_en and mem_wr_en both high at acceptance SHALL be treated as a write and SHALL set proto_err, which stays 1 until reset.
REQ-023 Deasserting the request, or changing address/data, after acceptance SHALL NOT cancel or alter the transaction; ack still pulses at cycle LATENCY.
REQ-024 Line index SHALL be mem_addr[ADDR_SIZE-1:log2(BYTE_NUM)]; no out-of-range case exists.
REQ-025 busy SHALL be high in Wait and Ack, low in Idle.
REQ-026 Back-to-back requests SHALL complete every LATENCY+1 cycles minimum.

Reset
REQ-027 Reset low SHALL immediately force Idle, counter 0, mem_ack 0, busy 0, proto_err 0, mem_rd_data 0.
REQ-028 Line storage SHALL NOT be reset; contents are undefined until written.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack; a write already accepted stays committed; first request after reset release is accepted normally.

Verification
REQ-030 Write addr 0x010, data 0x1122334455667788, sel 0xFF, LATENCY=3 -> ack high exactly in cycle 3, busy high cycles 1-3.
REQ-031 Then read addr 0x017 (same line) -> ack at cycle 3, mem_rd_data 0x1122334455667788 during ack and held afterwards.
REQ-032 Write 0xAAAAAAAAAAAAAAAA with sel 0x0F to same line, read -> 0x11223344AAAAAAAA.
REQ-033 rd_en and wr_en high together with data 0x5 -> write performed, proto_err 1 and sticky across later normal transactions.
REQ-034 Request held high through ack into next cycle -> second transaction accepted in cycle after ack, second ack LATENCY cycles later; no extra ack.
REQ-035 Reset pulsed low in Wait -> no ack, busy 0 immediately; subsequent read completes with ack at LATENCY.
